fp_norm_sequencer: RTL

//  Multi-cycle normalisation controller for the FP add/sub path of the radix-3 butterfly.

---
 rtl/fp_norm_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fp_norm_sequencer.sv
// Multi-cycle normaliser for the butterfly FP add/sub path: carry right shift or
// bounded left shift (STEP bits per cycle), with zero/overflow/underflow detection.
module fp_norm_sequencer #(
    parameter int unsigned MW   = 24,
    parameter int unsigned EW   = 8,
    parameter int unsigned STEP = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] in_mant,
    input  logic [EW-1:0] in_exp,
    input  logic          in_carry,
    input  logic          in_as,
    input  logic          in_bs,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_mant,
    output logic [EW-1:0] out_exp,
    output logic          out_zero,
    output logic          out_ovf,
    output logic          out_unf,
    output logic          busy
);

    localparam int unsigned LZW = $clog2(MW + 1);
    localparam int unsigned CW  = (EW > LZW) ? EW : LZW;
    localparam logic [EW-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0] OVF_TH   = EXP_ONES - EW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CARRY,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q;
    logic [MW-1:0] mant_q;
    logic [EW-1:0] exp_q;
    logic          zero_q;
    logic          ovf_q;
    logic          unf_q;

    logic [LZW-1:0] lz;
    logic [LZW-1:0] sh;
    logic [CW-1:0]  exp_w;
    logic [CW-1:0]  sh_w;

    // Scan upward so the highest set bit writes last and wins.
    always_comb begin
        lz = LZW'(MW);
        for (int unsigned i = 0; i < MW; i++) begin
            if (mant_q[i]) lz = LZW'(MW - 1 - i);
        end
        sh    = (lz > LZW'(STEP)) ? LZW'(STEP) : lz;
        exp_w = CW'(exp_q);
        sh_w  = CW'(sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mant_q  <= '0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mant_q <= in_mant;
                        exp_q  <= in_exp;
                        zero_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        unf_q  <= 1'b0;
                        if (!(in_as ^ in_bs)) begin
                            state_q <= in_carry ? CARRY : DONE;
                        end else if (in_mant == '0) begin
                            zero_q  <= 1'b1;
                            exp_q   <= '0;
                            state_q <= DONE;
                        end else if (in_mant[MW-1]) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                CARRY: begin
                    if (exp_q >= OVF_TH) begin
                        ovf_q  <= 1'b1;
                        exp_q  <= EXP_ONES;
                        mant_q <= '0;
                    end else begin
                        mant_q <= {1'b1, mant_q[MW-1:1]};
                        exp_q  <= exp_q + EW'(1);
                    end
                    state_q <= DONE;
                end
                SHIFT: begin
                    if (exp_w <= sh_w) begin
                        unf_q   <= 1'b1;
                        mant_q  <= '0;
                        exp_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        // exp > sh here, so the narrowed subtrahend cannot wrap
                        mant_q <= mant_q << sh;
                        exp_q  <= exp_q - EW'(sh_w);
                        if (sh == lz) state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        zero_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_mant  = mant_q;
    assign out_exp   = exp_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;

endmodule
